// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and one-hot helper shared by the burst arbiter files.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    // Wide enough for any practical requester count; callers size-cast to N.
    function automatic logic [63:0] onehot(input int idx, input int n);
        return (idx >= 0 && idx < n) ? 64'd1 << idx : 64'd0;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set bit of req & mask, scanning upward from start with wrap.
module rr_priority_picker #(
    parameter int N = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  m;
    logic [N-1:0]  rot;
    logic [IW-1:0] pos;

    assign m     = req & mask;
    assign found = |m;

    // Rotate so start lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot = '0;
        pos = '0;
        for (int i = 0; i < N; i++)
            rot[i] = m[(i + int'(start)) % N];
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) pos = IW'(i);
    end

    assign idx = IW'((int'(pos) + int'(start)) % N);

endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter that lets an owner hold the grant for up to MAX_BURST cycles.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int N = 16,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(N),
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_id_o,
    output logic          gnt_valid_o
);

    arb_state_e    state, state_n;
    logic [IW-1:0] ptr, ptr_n, id_n, start, idx;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  mask;
    logic          found, take;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // While granted, search after the owner and skip it; when idle, resume from ptr.
    assign start = (state == ARB_GRANT) ? inc(gnt_id_o) : ptr;
    assign mask  = (state == ARB_GRANT) ? ~N'(onehot(int'(gnt_id_o), N)) : '1;

    rr_priority_picker #(.N(N)) u_pick (
        .req   (req_i),
        .mask  (mask),
        .start (start),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        id_n    = gnt_id_o;
        take    = 1'b0;
        if (state == ARB_IDLE)
            take = found;
        else if (!req_i[gnt_id_o]) begin
            take = found;
            if (!found) begin
                state_n = ARB_IDLE;
                id_n    = '0;
                cnt_n   = '0;
            end
        end else if (cnt != CW'(MAX_BURST - 1))
            cnt_n = cnt + 1'b1;
        else begin
            take  = found;
            cnt_n = '0;
        end
        if (take) begin
            state_n = ARB_GRANT;
            id_n    = idx;
            cnt_n   = '0;
        end
        ptr_n = take ? inc(idx) : ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            gnt_id_o    <= '0;
            gnt_o       <= '0;
            gnt_valid_o <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            gnt_id_o    <= id_n;
            gnt_o       <= (state_n == ARB_GRANT) ? N'(onehot(int'(id_n), N)) : '0;
            gnt_valid_o <= state_n == ARB_GRANT;
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: directed scenarios with hand-derived grants, then a random soak on invariants and starvation.
module tb_rr_burst_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req_i = '0;
    logic [15:0] gnt_o;
    logic [3:0]  gnt_id_o;
    logic        gnt_valid_o;
    int          tests = 0;
    int          fails = 0;

    rr_burst_arbiter #(.N(16), .MAX_BURST(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_id_o    (gnt_id_o),
        .gnt_valid_o (gnt_valid_o)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [15:0] r);
        req_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] eg);
        logic [3:0] ei = '0;
        for (int i = 0; i < 16; i++)
            if (eg[i]) ei = 4'(i);
        tests++;
        assert (gnt_o === eg) else begin
            fails++;
            $error("FAIL %s gnt_o got %h expected %h", tag, gnt_o, eg);
        end
        tests++;
        assert (gnt_valid_o === (eg != 16'h0)) else begin
            fails++;
            $error("FAIL %s gnt_valid_o got %b expected %b", tag, gnt_valid_o, eg != 16'h0);
        end
        tests++;
        assert (gnt_id_o === ei) else begin
            fails++;
            $error("FAIL %s gnt_id_o got %0d expected %0d", tag, gnt_id_o, ei);
        end
    endtask

    initial begin
        logic [15:0] r;
        int          w [16];
        // 1. reset with everyone requesting, then release with requester 0
        reset = 1'b1;
        repeat (3) begin
            step(16'hFFFF);
            chk("reset_hold", 16'h0000);
        end
        reset = 1'b0;
        step(16'h0001);
        chk("reset_release", 16'h0001);
        // 2. burst limit alternation between 0 and 1 (first 0001 cycle already seen)
        for (int k = 0; k < 15; k++) begin
            step(16'h0003);
            chk("burst_limit", (((k + 1) / 4) % 2) ? 16'h0002 : 16'h0001);
        end
        step(16'h0000);
        chk("burst_idle", 16'h0000);
        // 3. early release: ptr=2, so lone 0001 re-enters via wrap
        step(16'h0001);
        chk("early_g1", 16'h0001);
        step(16'h0011);
        chk("early_g2", 16'h0001);
        req_i = 16'h0010;
        #1;
        chk("early_stale", 16'h0001);
        step(16'h0010);
        chk("early_switch", 16'h0010);
        step(16'h0000);
        chk("early_idle", 16'h0000);
        // 4. single requester keeps the grant with no gap
        for (int k = 0; k < 10; k++) begin
            step(16'h8000);
            chk("single_hold", 16'h8000);
        end
        step(16'h0000);
        chk("single_drop", 16'h0000);
        // 5. wrap from owner 15 to 0 and back
        step(16'h8000);
        chk("wrap_start", 16'h8000);
        for (int k = 0; k < 9; k++) begin
            step(16'h8001);
            chk("wrap", (((k + 1) / 4) % 2) ? 16'h0001 : 16'h8000);
        end
        step(16'h0000);
        chk("wrap_idle", 16'h0000);
        // 6. reset in the second cycle of a grant to 5, ptr returns to 0
        step(16'h0020);
        chk("mid_g1", 16'h0020);
        step(16'h0020);
        chk("mid_g2", 16'h0020);
        reset = 1'b1;
        step(16'h0020);
        chk("mid_reset", 16'h0000);
        reset = 1'b0;
        step(16'h8001);
        chk("mid_release", 16'h0001);
        // random soak: sticky requests, invariants and wait bound (N-1)*MAX_BURST+1
        r = 16'h8001;
        for (int i = 0; i < 16; i++) w[i] = 0;
        repeat (3000) begin
            for (int i = 0; i < 16; i++)
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            step(r);
            tests++;
            assert ($onehot0(gnt_o)) else begin
                fails++;
                $error("FAIL rnd_onehot gnt_o got %h expected onehot0", gnt_o);
            end
            tests++;
            assert (gnt_valid_o === (gnt_o != 16'h0)) else begin
                fails++;
                $error("FAIL rnd_valid got %b expected %b", gnt_valid_o, gnt_o != 16'h0);
            end
            tests++;
            assert (gnt_o === (gnt_valid_o ? 16'h1 << gnt_id_o : 16'h0) && (gnt_valid_o || gnt_id_o == 4'd0)) else begin
                fails++;
                $error("FAIL rnd_id gnt_id_o got %0d with gnt_o %h", gnt_id_o, gnt_o);
            end
            for (int i = 0; i < 16; i++) begin
                w[i] = (r[i] && !gnt_o[i]) ? w[i] + 1 : 0;
                tests++;
                assert (w[i] <= 61) else begin
                    fails++;
                    $error("FAIL rnd_starve req %0d waited %0d expected <= 61", i, w[i]);
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
